// File: rtl/fifo_lfsr.sv
// First-word fall-through FIFO between the LFSR producer and the consumer.
// Sticky overflow flag; clear flushes pointers without touching storage.
module fifo_lfsr #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic             push;
  logic             pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];
  assign count     = count_q;
  assign overflow  = overflow_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (in_valid && full)
        overflow_q <= 1'b1;
    end
  end

  // Storage has no reset; only accepted pushes write it.
  always_ff @(posedge clk) begin
    if (!reset && !clear && push)
      mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_fifo_lfsr.sv
// Directed self-checking bench for fifo_lfsr.
// Linear stimulus; each check is an immediate assertion.
module tb_fifo_lfsr;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             clear;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [3:0]       count;
  logic             full;
  logic             empty;
  logic             overflow;

  int n_assert = 0;
  int n_fail   = 0;

  fifo_lfsr #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .count(count),
    .full(full),
    .empty(empty),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] exp);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk(tag, 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // pop while empty does nothing
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("empty_pop_count", 32'(count), 32'd0);
    chk("empty_pop_rdptr", 32'(dut.rd_ptr), 32'd0);

    // three words, one-cycle latency
    push(16'h0011);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data", 32'(out_data), 32'h0011);
    push(16'h0022);
    push(16'h0033);
    chk("three_count", 32'(count), 32'd3);
    chk("three_head", 32'(out_data), 32'h0011);
    pop_chk("three_pop0", 16'h0011);
    pop_chk("three_pop1", 16'h0022);
    pop_chk("three_pop2", 16'h0033);
    chk("three_empty", 32'(empty), 32'd1);

    // fill and overflow
    for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_ovf_pre", 32'(overflow), 32'd0);
    push(16'hFFFF);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++)
      pop_chk($sformatf("fill_pop%0d", i), 16'h0100 + 16'(i));
    chk("fill_empty", 32'(empty), 32'd1);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_wrptr", 32'(dut.wr_ptr), 32'd0);

    // wrap-around
    for (int i = 0; i < 6; i++) push(16'h0900 + 16'(i));
    for (int i = 0; i < 6; i++)
      pop_chk($sformatf("wrap_a%0d", i), 16'h0900 + 16'(i));
    for (int i = 0; i < 5; i++) push(16'h0A00 + 16'(i));
    chk("wrap_count", 32'(count), 32'd5);
    chk("wrap_wrptr", 32'(dut.wr_ptr), 32'd3);
    chk("wrap_rdptr", 32'(dut.rd_ptr), 32'd6);
    for (int i = 0; i < 5; i++)
      pop_chk($sformatf("wrap_b%0d", i), 16'h0A00 + 16'(i));
    chk("wrap_empty", 32'(empty), 32'd1);

    // streaming at count=4
    for (int i = 0; i < 4; i++) push(16'h0B00 + 16'(i));
    chk("stream_count0", 32'(count), 32'd4);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 16'h0B04 + 16'(i);
      chk($sformatf("stream_out%0d", i), 32'(out_data),
          32'h0B00 + 32'(i));
      tick();
      chk($sformatf("stream_cnt%0d", i), 32'(count), 32'd4);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // build count=5 with overflow set
    for (int i = 0; i < 4; i++) push(16'h0C00 + 16'(i));
    push(16'hFFFF);
    chk("pre_clr_ovf", 32'(overflow), 32'd1);
    pop_chk("pre_clr_pop0", 16'h0B0A);
    pop_chk("pre_clr_pop1", 16'h0B0B);
    pop_chk("pre_clr_pop2", 16'h0B0C);
    chk("pre_clr_count", 32'(count), 32'd5);

    // clear beats a simultaneous push
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_empty", 32'(empty), 32'd1);
    chk("clr_ovf2", 32'(overflow), 32'd0);
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    push(16'h1234);
    chk("post_clr_count", 32'(count), 32'd1);
    chk("post_clr_data", 32'(out_data), 32'h1234);

    // reset mid-transfer beats push/pop/clear
    push(16'h5678);
    reset     = 1'b1;
    clear     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = 16'h9999;
    tick();
    reset     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
